// File: rtl/enh_noc_pkg.sv
// rtl/enh_noc_pkg.sv - shared flit-format constants for the NoC merge/demux stages
package enh_noc_pkg;

    // Default flit geometry: valid bit(s) at the MSB end, payload below.
    localparam int DEF_WORD_WIDTH = 16;
    localparam int DEF_VAL_BIT    = 1;

    // Bit position of the valid flag in a default-width flit; the merge stage
    // keys on the same position.
    localparam int VALID_POS      = DEF_WORD_WIDTH - 1;

    // Output port selected by the routing bit of the payload.
    typedef enum logic {
        PORT_1 = 1'b0,
        PORT_2 = 1'b1
    } port_sel_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count
//
// Purpose: circular buffer of 2**log_depth entries of width bits.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset (count/pointers)
//   push_i, din_i      write request and data; ignored when full unless
//                      a pop happens on the same edge
//   pop_i, dout_o      read request (ignored when empty) and head entry
//   count_o            occupancy 0..2**log_depth
//   empty_o, full_o    occupancy flags
module sync_fifo #(
    parameter int width     = 15,
    parameter int log_depth = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic [width-1:0]     din_i,
    output logic [width-1:0]     dout_o,
    output logic [log_depth:0]   count_o,
    output logic                 empty_o,
    output logic                 full_o
);

    localparam int depth = 1 << log_depth;

    logic [width-1:0]     mem_q [depth];
    logic [log_depth-1:0] wr_ptr_q, wr_ptr_d;
    logic [log_depth-1:0] rd_ptr_q, rd_ptr_d;
    logic [log_depth:0]   count_q, count_d;
    logic                 do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (log_depth+1)'(depth));
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // A pop frees the slot on the same edge, so a full FIFO still takes a
    // push when it is popped simultaneously.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; only entries below count_q are ever read.
    always_ff @(posedge clk_i) begin
        if (!rst_i && do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/enh_demux.sv
// rtl/enh_demux.sv - two-port flit demultiplexer with per-port FIFOs
//
// Purpose: routes valid upstream flits by payload[route_bit] into one of two
// FIFOs and drains each FIFO into a registered output port.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in                upstream flit, valid at MSB, payload in low bits
//   full_1, full_2    downstream back-pressure per port
//   out_1, out_2      registered output flits (all zeros when idle)
//   busy              back-pressure to upstream (a FIFO is at D-1 or more)
//   drop_cnt          saturating count of flits lost to a full FIFO
module enh_demux
    import enh_noc_pkg::*;
#(
    parameter int word_width     = DEF_WORD_WIDTH,
    parameter int val_bit        = DEF_VAL_BIT,
    parameter int log_buffer_len = 2,
    parameter int route_bit      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [word_width-1:0] in,
    input  logic                  full_1,
    input  logic                  full_2,
    output logic [word_width-1:0] out_1,
    output logic [word_width-1:0] out_2,
    output logic                  busy,
    output logic [7:0]            drop_cnt
);

    localparam int pw    = word_width - val_bit;
    localparam int depth = 1 << log_buffer_len;

    logic                    in_valid;
    logic [pw-1:0]           in_payload;
    port_sel_e               route;

    logic                    push_1, push_2, pop_1, pop_2;
    logic [pw-1:0]           head_1, head_2;
    logic [log_buffer_len:0] count_1, count_2;
    logic                    empty_1, empty_2, fifo_full_1, fifo_full_2;
    logic                    drop;

    logic [val_bit-1:0]      valid_field;
    logic [word_width-1:0]   out_1_q, out_1_d;
    logic [word_width-1:0]   out_2_q, out_2_d;
    logic [7:0]              drop_cnt_q, drop_cnt_d;

    assign in_valid   = in[word_width-1];
    assign in_payload = in[pw-1:0];
    assign route      = port_sel_e'(in_payload[route_bit]);

    assign push_1 = !rst && in_valid && (route == PORT_1);
    assign push_2 = !rst && in_valid && (route == PORT_2);

    // full_x only gates the pop decision on this edge; nothing is lost.
    assign pop_1  = !rst && !empty_1 && !full_1;
    assign pop_2  = !rst && !empty_2 && !full_2;

    // At most one push per edge, so at most one drop per edge.
    assign drop = (push_1 && fifo_full_1 && !pop_1) ||
                  (push_2 && fifo_full_2 && !pop_2);

    sync_fifo #(
        .width     (pw),
        .log_depth (log_buffer_len)
    ) u_fifo_1 (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push_1),
        .pop_i   (pop_1),
        .din_i   (in_payload),
        .dout_o  (head_1),
        .count_o (count_1),
        .empty_o (empty_1),
        .full_o  (fifo_full_1)
    );

    sync_fifo #(
        .width     (pw),
        .log_depth (log_buffer_len)
    ) u_fifo_2 (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push_2),
        .pop_i   (pop_2),
        .din_i   (in_payload),
        .dout_o  (head_2),
        .count_o (count_2),
        .empty_o (empty_2),
        .full_o  (fifo_full_2)
    );

    // Regenerated valid field: flag at the MSB, any extra valid bits zero.
    always_comb begin
        valid_field              = '0;
        valid_field[val_bit-1]   = 1'b1;
    end

    always_comb begin
        out_1_d    = pop_1 ? {valid_field, head_1} : '0;
        out_2_d    = pop_2 ? {valid_field, head_2} : '0;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_1_q    <= '0;
            out_2_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            out_1_q    <= out_1_d;
            out_2_q    <= out_2_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // One-entry margin so upstream can react a cycle late without a drop.
    assign busy = (32'(count_1) >= 32'(depth - 1)) ||
                  (32'(count_2) >= 32'(depth - 1));

    assign out_1    = out_1_q;
    assign out_2    = out_2_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_enh_demux.sv
// tb/tb_enh_demux.sv - scoreboard bench for enh_demux against a queue model
module tb_enh_demux;
    import enh_noc_pkg::*;

    localparam int D = 4;

    typedef struct {
        int          due;
        logic [15:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_s = '0;
    logic        full_1 = 1'b0;
    logic        full_2 = 1'b0;
    logic [15:0] out_1, out_2;
    logic        busy;
    logic [7:0]  drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: plain queues of payloads per port.
    logic [14:0] q1[$];
    logic [14:0] q2[$];
    exp_t        exp1[$];
    exp_t        exp2[$];
    int          edge_n = 0;
    int          m_drop = 0;
    logic        m_busy = 1'b0;
    logic        live = 1'b0;

    enh_demux #(
        .word_width     (16),
        .val_bit        (1),
        .log_buffer_len (2),
        .route_bit      (0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in       (in_s),
        .full_1   (full_1),
        .full_2   (full_2),
        .out_1    (out_1),
        .out_2    (out_2),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_n, act, req);
        end
    endtask

    // Model: each edge, pop a head if the port is not full, then accept the
    // incoming flit if its queue has room after that pop.
    always @(posedge clk) begin
        exp_t        e;
        logic [14:0] p;
        edge_n++;
        if (rst) begin
            q1.delete();
            q2.delete();
            m_drop = 0;
            live   = 1'b1;
        end else if (live) begin
            if (q1.size() > 0 && !full_1) begin
                e.due = edge_n;
                e.val = {1'b1, q1.pop_front()};
                exp1.push_back(e);
            end
            if (q2.size() > 0 && !full_2) begin
                e.due = edge_n;
                e.val = {1'b1, q2.pop_front()};
                exp2.push_back(e);
            end
            if (in_s[VALID_POS]) begin
                p = in_s[14:0];
                if (p[0] == 1'b0) begin
                    if (q1.size() < D) q1.push_back(p);
                    else if (m_drop < 255) m_drop++;
                end else begin
                    if (q2.size() < D) q2.push_back(p);
                    else if (m_drop < 255) m_drop++;
                end
            end
        end
        m_busy = (q1.size() >= D - 1) || (q2.size() >= D - 1);
    end

    // Monitor: consume an expectation whenever a port presents a flit.
    always @(negedge clk) begin
        exp_t e;
        if (live) begin
            if (out_1 != 16'h0) begin
                if (exp1.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL out_1 unexpected at edge %0d: got %0h, expected idle 0", edge_n, out_1);
                end else begin
                    e = exp1.pop_front();
                    check("out_1 value", int'(out_1), int'(e.val));
                    check("out_1 edge", edge_n, e.due);
                end
            end else if (exp1.size() > 0 && exp1[0].due <= edge_n) begin
                e = exp1.pop_front();
                n_checks++; n_errors++;
                $display("FAIL out_1 missing at edge %0d: got 0, expected %0h", edge_n, e.val);
            end
            if (out_2 != 16'h0) begin
                if (exp2.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL out_2 unexpected at edge %0d: got %0h, expected idle 0", edge_n, out_2);
                end else begin
                    e = exp2.pop_front();
                    check("out_2 value", int'(out_2), int'(e.val));
                    check("out_2 edge", edge_n, e.due);
                end
            end else if (exp2.size() > 0 && exp2[0].due <= edge_n) begin
                e = exp2.pop_front();
                n_checks++; n_errors++;
                $display("FAIL out_2 missing at edge %0d: got 0, expected %0h", edge_n, e.val);
            end
            check("busy", int'(busy), int'(m_busy));
            check("drop_cnt", int'(drop_cnt), m_drop);
        end
    end

    // Inputs change 2 time units after a rising edge and hold for one cycle.
    task automatic cyc(input logic [15:0] f, input logic f1, input logic f2, input logic r);
        @(posedge clk);
        #2;
        in_s   = f;
        full_1 = f1;
        full_2 = f2;
        rst    = r;
    endtask

    task automatic idle(input int n, input logic f1, input logic f2);
        for (int i = 0; i < n; i++) cyc(16'h0, f1, f2, 1'b0);
    endtask

    initial begin
        logic [15:0] f;
        // Reset
        cyc(16'h0, 1'b0, 1'b0, 1'b1);
        cyc(16'h0, 1'b0, 1'b0, 1'b1);
        cyc(16'h0, 1'b0, 1'b0, 1'b0);
        // Single flit to port 1, then back-to-back flits to both ports
        cyc(16'h8002, 1'b0, 1'b0, 1'b0);
        idle(4, 1'b0, 1'b0);
        cyc(16'h8003, 1'b0, 1'b0, 1'b0);
        cyc(16'h8004, 1'b0, 1'b0, 1'b0);
        idle(4, 1'b0, 1'b0);
        // Port 1 stalled with exactly D flits, then released
        for (int i = 0; i < 4; i++) cyc(16'h8010 + 16'(i * 2), 1'b1, 1'b0, 1'b0);
        idle(3, 1'b1, 1'b0);
        idle(8, 1'b0, 1'b0);
        // Port 1 stalled with 6 flits while port 2 keeps flowing
        for (int i = 0; i < 6; i++) begin
            cyc(16'h8020 + 16'(i * 2), 1'b1, 1'b0, 1'b0);
            cyc(16'h8041 + 16'(i * 2), 1'b1, 1'b0, 1'b0);
        end
        idle(8, 1'b0, 1'b0);
        // Full FIFO 1: push and pop on the same edge
        for (int i = 0; i < 4; i++) cyc(16'h8060 + 16'(i * 2), 1'b1, 1'b0, 1'b0);
        cyc(16'h8070, 1'b0, 1'b0, 1'b0);
        idle(8, 1'b0, 1'b0);
        // Randomized traffic and back-pressure
        for (int i = 0; i < 400; i++) begin
            f = 16'($urandom);
            if ($urandom_range(0, 9) < 3) f[15] = 1'b0;
            cyc(f, $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 3, 1'b0);
        end
        idle(8, 1'b0, 1'b0);
        // Drop counter saturation
        for (int i = 0; i < 262; i++) cyc(16'h8000 | 16'(($urandom & 16'h7FFE)), 1'b1, 1'b0, 1'b0);
        idle(2, 1'b1, 1'b0);
        // Reset with three flits buffered, then release the stall
        for (int i = 0; i < 3; i++) cyc(16'h8100 + 16'(i * 2), 1'b1, 1'b0, 1'b0);
        cyc(16'h8000, 1'b1, 1'b0, 1'b1);
        cyc(16'h0, 1'b0, 1'b0, 1'b0);
        idle(8, 1'b0, 1'b0);
        @(negedge clk);
        check("exp1 drained", exp1.size(), 0);
        check("exp2 drained", exp2.size(), 0);
        check("model q1 empty", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/enh_demux.md
ENH_DEMUX -- requirements
Module: enh_demux

Interface
REQ-001 Parameter word_width, default 16, total flit width including valid bits.
REQ-002 Parameter val_bit, default 1, number of valid bits at flit MSB end.
REQ-003 Parameter log_buffer_len, default 2, log2 of per-output FIFO depth (depth D = 2**log_buffer_len).
REQ-004 Parameter route_bit, default 0, payload bit index selecting the output port.
REQ-005 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 Port rst  input  1  reset, synchronous, active-high.
REQ-007 Port in  input  word_width  upstream flit; in[word_width-1] is the valid bit, in[word_width-val_bit-1:0] the payload.
REQ-008 Port full_1  input  1  downstream port 1 cannot accept.
REQ-009 Port full_2  input  1  downstream port 2 cannot accept.
REQ-010 Port out_1  output  word_width  flit to port 1, same format as in.
REQ-011 Port out_2  output  word_width  flit to port 2, same format as in.
REQ-012 Port busy  output  1  back-pressure to upstream merge stage.
REQ-013 Port drop_cnt  output  8  saturating count of discarded flits.

Function
REQ-014 Flit accepted at a rising edge when in valid bit = 1; payload routed to FIFO 1 if payload[route_bit] = 0, else FIFO 2.
REQ-015 Payload stored and forwarded unmodified; output valid bit regenerated, never copied from in.
REQ-016 Each FIFO: D entries, count 0..D; push and pop in same edge leave count unchanged; pointers wrap modulo D.
REQ-017 Accepted flit targeting a FIFO with count = D and no pop that edge is discarded; drop_cnt increments, saturating at 255.
REQ-018 Output stage x (x = 1, 2), each edge: if FIFO x non-empty and full_x = 0, pop head and register out_x = {valid=1, head payload}; otherwise register out_x = all zeros.
REQ-019 Output valid is a one-cycle pulse per flit; consecutive flits may appear on consecutive cycles.
REQ-020 Latency: flit on in during cycle c appears on out_x during cycle c+2 when FIFO x was empty and full_x = 0 at edge c+1.
REQ-021 full_x sampled at the pop edge only; full_x rising mid-stream stalls port x without loss; the other port continues independently.
REQ-022 busy combinational: 1 when either FIFO count >= D-1, else 0 (one-entry margin for upstream one-cycle reaction).
REQ-023 Per-port ordering preserved; no ordering relation between ports.

Reset
REQ-024 rst = 1 at an edge: FIFO counts and pointers to 0, out_1 and out_2 to all zeros, drop_cnt to 0; in ignored that edge.
REQ-025 busy = 0 in the cycle following a reset edge.
REQ-026 Reset mid-operation discards all buffered flits; no partial flit emitted after reset.

Structure
REQ-027 Package enh_noc_pkg holds default word_width, val_bit and the valid-bit position constant shared with the merge stage.
REQ-028 One sub-module sync_fifo (single-clock, parameterised width and log depth, push/pop/count/empty/full), instantiated twice.
REQ-029 Routing, drop counter and output registers reside in enh_demux.

Verification
REQ-030 Reset, then in = 16'h8002 (route bit 0) for one cycle, full_1 = 0 -> out_1 = 16'h8002 exactly two cycles later for one cycle, out_2 stays 0.
REQ-031 in = 16'h8003 then 16'h8004 on consecutive cycles -> out_2 = 16'h8003 at c+2, out_1 = 16'h8004 at c+3.
REQ-032 full_1 = 1, send 4 flits to port 1 (D = 4) -> busy rises after 3rd accepted flit, out_1 all zeros; release full_1 -> 4 flits out in order on 4 consecutive cycles.
REQ-033 full_1 = 1, send 6 flits to port 1 -> drop_cnt = 2, first 4 retained; port-2 traffic meanwhile unaffected.
REQ-034 Fill FIFO 1 to D, drive a push and a pop in same edge -> count stays D, drop_cnt unchanged.
REQ-035 Assert rst with 3 flits buffered -> next cycle outputs zero, busy = 0, drop_cnt = 0, no buffered flit emitted afterwards.
